// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, instruction formats and loader types
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U
    } fmt_e;

    // Decoded field bundle; in_last is session control and travels separately
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// rtl/instr_field_encoder.sv - combinational RV32I fields-to-machine-word encoder
module instr_field_encoder
    import riscv_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output fmt_e          fmt,
    output logic          legal
);

    logic shift_imm;

    assign shift_imm = (fields.opcode == OP_IMM) &&
                       ((fields.funct3 == 3'b001) || (fields.funct3 == 3'b101));

    // Classify the opcode into its encoding format
    always_comb begin
        fmt   = FMT_R;
        legal = 1'b1;
        case (fields.opcode)
            OP_R:                     fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_JAL:                   fmt = FMT_J;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            default:                  legal = 1'b0;
        endcase
    end

    // Scatter the fields into the 32-bit word according to the format
    always_comb begin
        word = 32'h0;
        if (legal) begin
            case (fmt)
                FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                               fields.rd, fields.opcode};
                FMT_I: begin
                    if (shift_imm)
                        word = {fields.funct7, fields.imm[4:0], fields.rs1, fields.funct3,
                                fields.rd, fields.opcode};
                    else
                        word = {fields.imm[11:0], fields.rs1, fields.funct3,
                                fields.rd, fields.opcode};
                end
                FMT_S: word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                               fields.imm[4:0], fields.opcode};
                FMT_B: word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                               fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
                FMT_J: word = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                               fields.imm[19:12], fields.rd, fields.opcode};
                FMT_U: word = {fields.imm[31:12], fields.rd, fields.opcode};
                default: word = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I field bundles and writes them to instruction memory
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e        state;
    instr_fields_t fields;
    logic [31:0]   enc_word;
    fmt_e          enc_fmt;
    logic          enc_legal;
    logic          accept;
    logic          write_ok;
    logic [ADDR_W:0] count_next;

    assign fields = '{opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    instr_field_encoder u_enc (
        .fields (fields),
        .word   (enc_word),
        .fmt    (enc_fmt),
        .legal  (enc_legal)
    );

    // The memory retires every registered write in one cycle, so LOAD can always
    // take a bundle except in a start cycle, which restarts the session instead.
    assign in_ready   = (state == ST_LOAD) && !start;
    assign accept     = in_valid && in_ready;
    // fmt is only meaningful for a legal opcode; both must agree before writing
    assign write_ok   = enc_legal && (enc_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U});
    assign count_next = count + 1'b1;

    // Session FSM, registered write port and word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            im_we    <= 1'b0;
            im_addr  <= BASE;
            im_wdata <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            im_we <= 1'b0;
            if (start) begin
                state <= ST_LOAD;
                busy  <= 1'b1;
                done  <= 1'b0;
                err   <= 1'b0;
                count <= '0;
            end else if (accept) begin
                if (write_ok) begin
                    im_we    <= 1'b1;
                    im_addr  <= BASE + count[ADDR_W-1:0];
                    im_wdata <= enc_word;
                    count    <= count_next;
                    if (in_last || (count_next == CAPACITY)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    // Filling the last slot without the program ending is an overflow
                    if (!in_last && (count_next == CAPACITY))
                        err <= 1'b1;
                end else begin
                    // Illegal bundle is consumed without a write
                    err <= 1'b1;
                    if (in_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, im_we, busy, done, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [10:0] count;

    logic        d2_in_ready, d2_im_we, d2_busy, d2_done, d2_err;
    logic [1:0]  d2_im_addr;
    logic [31:0] d2_im_wdata;
    logic [2:0]  d2_count;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .im_we(d2_im_we), .im_addr(d2_im_addr), .im_wdata(d2_im_wdata),
        .busy(d2_busy), .done(d2_done), .err(d2_err), .count(d2_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] word;
        int          at;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  slot  = 0;
    int  w2    = 0;
    int  last2 = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Spec-level encoding: {legal, word}
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        case (op)
            7'b0110011: return {1'b1, f7, rs2, rs1, f3, rd, op};
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    return {1'b1, f7, imm[4:0], rs1, f3, rd, op};
                return {1'b1, imm[11:0], rs1, f3, rd, op};
            end
            7'b0000011, 7'b1100111: return {1'b1, imm[11:0], rs1, f3, rd, op};
            7'b0100011: return {1'b1, imm[11:5], rs2, rs1, f3, imm[4:0], op};
            7'b1100011: return {1'b1, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            7'b1101111: return {1'b1, imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            7'b0110111, 7'b0010111: return {1'b1, imm[31:12], rd, op};
            default: return 33'h0;
        endcase
    endfunction

    // Every write the DUT makes must match the oldest expected write, in the expected cycle
    always @(negedge clk) begin : compare
        wr_t e;
        if (!rst && im_we) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write: got addr %0d data %h want no write", im_addr, im_wdata);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 64'(im_addr), 64'(e.addr));
                chk("wr_data", 64'(im_wdata), 64'(e.word));
                chk("wr_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d2_im_we) begin
            w2++;
            last2 = int'(d2_im_addr);
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] lit, input bit use_lit);
        logic [32:0] m;
        bit          got;
        wr_t         e;
        m = model_enc(op, f3, f7, rd, rs1, rs2, imm);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (m[32]) begin
                    e.addr = slot;
                    e.word = use_lit ? lit : m[31:0];
                    e.at   = cyc + 1;
                    q.push_back(e);
                    slot++;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 20 cycles want 1 (opcode %b)", op);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        chk("ready_in_start_cycle", 64'(in_ready), 64'(0));
        slot = 0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_im_we"}, 64'(im_we), 64'(0));
        chk({tag, "_im_addr"}, 64'(im_addr), 64'(0));
        chk({tag, "_im_wdata"}, 64'(im_wdata), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // add x3,x1,x2 ; sub x5,x6,x7 back-to-back
        pulse_start();
        send(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
        send(7'b0110011, 3'b000, 7'b0100000, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h407302B3, 1'b1);
        idle(2);
        chk("t1_count", 64'(count), 64'(2));
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_done", 64'(done), 64'(0));

        // addi x1,x0,-1 ; sw x2,8(x1) ; beq x1,x2,-4 ; jal x1,8 (last)
        pulse_start();
        send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1, 1'b0, 32'hFFF00093, 1'b1);
        send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423, 1'b1);
        send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 32'hFE208EE3, 1'b1);
        send(7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, 1'b1);
        idle(2);
        chk("t2_done", 64'(done), 64'(1));
        chk("t2_count", 64'(count), 64'(4));
        chk("t2_err", 64'(err), 64'(0));
        chk("t2_busy", 64'(busy), 64'(0));
        chk("t2_in_ready", 64'(in_ready), 64'(0));

        // illegal opcode between two legal words
        pulse_start();
        send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0);
        send(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0, 1'b0);
        idle(1);
        chk("t3_err_after_illegal", 64'(err), 64'(1));
        send(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b1);
        idle(2);
        chk("t3_err", 64'(err), 64'(1));
        chk("t3_count", 64'(count), 64'(2));
        chk("t3_done", 64'(done), 64'(1));

        // four legal words without last: small instance overflows
        pulse_start();
        w2 = 0;
        send(7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h0, 1'b0);
        send(7'b0000011, 3'b010, 7'd0, 5'd4, 5'd2, 5'd0, 32'd12, 1'b0, 32'h0, 1'b0);
        send(7'b0010011, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0, 32'h00311093, 1'b1);
        send(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd2, 1'b0, 32'h40215093, 1'b1);
        idle(2);
        chk("ovf_done", 64'(d2_done), 64'(1));
        chk("ovf_err", 64'(d2_err), 64'(1));
        chk("ovf_count", 64'(d2_count), 64'(4));
        chk("ovf_in_ready", 64'(d2_in_ready), 64'(0));
        chk("ovf_writes", 64'(w2), 64'(4));
        chk("ovf_last_addr", 64'(last2), 64'(3));
        chk("big_count", 64'(count), 64'(4));
        chk("big_err", 64'(err), 64'(0));
        chk("big_busy", 64'(busy), 64'(1));

        // stalled in_valid, then reset with a write in flight
        pulse_start();
        send(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 32'h0, 1'b0);
        idle(2);
        send(7'b0110011, 3'b111, 7'd0, 5'd9, 5'd10, 5'd11, 32'd0, 1'b0, 32'h0, 1'b0);
        idle(1);
        send(7'b0010111, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        #2;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pulse_start();
        send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1, 1'b0, 32'hFFF00093, 1'b1);
        idle(2);
        chk("t5_count", 64'(count), 64'(1));

        // start one cycle after an accept: pending word still lands, session restarts
        send(7'b1111111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0);
        send(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
        pulse_start();
        chk("t6_err_cleared", 64'(err), 64'(0));
        chk("t6_count_cleared", 64'(count), 64'(0));
        chk("t6_im_we_low", 64'(im_we), 64'(0));
        send(7'b0110011, 3'b000, 7'b0100000, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h407302B3, 1'b1);
        idle(3);
        chk("t6_count", 64'(count), 64'(1));
        chk("drain", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
